// File: rtl/bitrev_perm_seq_if.sv
// Swap-request channel between the bit-reversal sequencer and the coefficient mover.
// The master raises swap_valid with an index pair; the slave accepts with swap_ready.
interface bitrev_perm_seq_if #(
  parameter int unsigned MaxBits = 12
);
  logic               swap_valid;
  logic               swap_ready;
  logic [MaxBits+1:0] swap_idx_a;
  logic [MaxBits+1:0] swap_idx_b;

  modport master (
    output swap_valid,
    output swap_idx_a,
    output swap_idx_b,
    input  swap_ready
  );

  modport slave (
    input  swap_valid,
    input  swap_idx_a,
    input  swap_idx_b,
    output swap_ready
  );
endinterface

// File: rtl/bitrev_perm_seq.sv
// Walks an in-place bit-reversal permutation over N = 2^nof_bits coefficients and
// issues one swap request (i, rev(i)) for every index with i < rev(i).
module bitrev_perm_seq #(
  parameter int unsigned MinBits = 6,
  parameter int unsigned MaxBits = 12
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      start_i,
  input  logic [3:0]                nof_bits_i,
  input  logic                      shift_i,
  input  logic                      abort_i,
  bitrev_perm_seq_if.master         swap_if,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      err_o
);

  // One extra bit so the N-1 = 2^MaxBits-1 comparison never wraps.
  localparam int unsigned CntW = MaxBits + 1;
  localparam int unsigned IdxW = MaxBits + 2;

  typedef enum logic [1:0] {
    StIdle,
    StScan,
    StIssue,
    StDone
  } state_e;

  state_e              r_state;
  logic [CntW-1:0]     r_cnt;
  logic [3:0]          r_nbits;
  logic                r_shift;
  logic                r_valid;
  logic [IdxW-1:0]     r_idx_a;
  logic [IdxW-1:0]     r_idx_b;
  logic                r_busy;
  logic                r_done;
  logic                r_err;

  logic [MaxBits-1:0]  w_rev_full;
  logic [MaxBits-1:0]  w_rev;
  logic [3:0]          w_rev_sh;
  logic [CntW-1:0]     w_last;
  logic                w_swap;
  logic                w_is_last;
  logic                w_legal;

  function automatic logic [IdxW-1:0] fmt_idx(input logic [MaxBits-1:0] idx,
                                               input logic               sh);
    return sh ? {idx, 2'b00} : {2'b00, idx};
  endfunction

  // Reverse all MaxBits bits, then shift down so only the low nof_bits bits remain reversed.
  always_comb begin
    w_rev_full = '0;
    for (int k = 0; k < int'(MaxBits); k++) begin
      w_rev_full[k] = r_cnt[int'(MaxBits) - 1 - k];
    end
  end

  assign w_rev_sh  = 4'(MaxBits) - r_nbits;
  assign w_rev     = w_rev_full >> w_rev_sh;
  assign w_last    = (CntW'(1) << r_nbits) - CntW'(1);
  assign w_swap    = r_cnt < {1'b0, w_rev};
  assign w_is_last = r_cnt == w_last;
  assign w_legal   = (nof_bits_i >= 4'(MinBits)) && (nof_bits_i <= 4'(MaxBits));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_nbits <= '0;
      r_shift <= 1'b0;
      r_valid <= 1'b0;
      r_idx_a <= '0;
      r_idx_b <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      if (abort_i && (r_state != StIdle)) begin
        // Abort beats a same-cycle handshake: the pending swap counts as not accepted.
        r_state <= StIdle;
        r_valid <= 1'b0;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          StIdle: begin
            if (start_i && !abort_i) begin
              if (w_legal) begin
                r_nbits <= nof_bits_i;
                r_shift <= shift_i;
                r_cnt   <= '0;
                r_busy  <= 1'b1;
                r_state <= StScan;
              end else begin
                r_err <= 1'b1;
              end
            end
          end
          StScan: begin
            if (w_swap) begin
              r_idx_a <= fmt_idx(r_cnt[MaxBits-1:0], r_shift);
              r_idx_b <= fmt_idx(w_rev, r_shift);
              r_valid <= 1'b1;
              r_state <= StIssue;
            end else if (w_is_last) begin
              r_done  <= 1'b1;
              r_state <= StDone;
            end else begin
              r_cnt <= r_cnt + CntW'(1);
            end
          end
          StIssue: begin
            if (swap_if.swap_ready) begin
              r_valid <= 1'b0;
              r_cnt   <= r_cnt + CntW'(1);
              r_state <= StScan;
            end
          end
          StDone: begin
            r_busy  <= 1'b0;
            r_state <= StIdle;
          end
          default: begin
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= StIdle;
          end
        endcase
      end
    end
  end

  assign swap_if.swap_valid = r_valid;
  assign swap_if.swap_idx_a = r_idx_a;
  assign swap_if.swap_idx_b = r_idx_b;
  assign busy_o             = r_busy;
  assign done_o             = r_done;
  assign err_o              = r_err;

endmodule

// File: tb/tb_bitrev_perm_seq.sv
// Randomized self-checking bench for bitrev_perm_seq; expected swap lists come from an
// arithmetic bit-reverse model of the permutation.
module tb_bitrev_perm_seq;
  localparam int unsigned MaxBits = 12;
  localparam int unsigned W       = MaxBits + 2;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       start_i = 1'b0;
  logic [3:0] nof_bits_i = 4'd0;
  logic       shift_i = 1'b0;
  logic       abort_i = 1'b0;
  logic       busy_o;
  logic       done_o;
  logic       err_o;

  int total = 0;
  int bad   = 0;

  bitrev_perm_seq_if #(.MaxBits(MaxBits)) swap_if ();

  bitrev_perm_seq #(.MinBits(6), .MaxBits(MaxBits)) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .start_i    (start_i),
    .nof_bits_i (nof_bits_i),
    .shift_i    (shift_i),
    .abort_i    (abort_i),
    .swap_if    (swap_if),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .err_o      (err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned rev_ref(input int unsigned i, input int unsigned n);
    int unsigned r = 0;
    for (int k = 0; k < int'(n); k++) r = r * 2 + ((i >> k) % 2);
    return r;
  endfunction

  function automatic int unsigned fmt_ref(input int unsigned x, input bit sh);
    return sh ? x * 4 : x;
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Runs one full permutation; inject pulses a conflicting start while busy.
  task automatic run_seq(input int unsigned n, input bit sh, input bit rand_ready,
                         input bit chk_lat, input bit inject);
    int unsigned exp_a[$];
    int unsigned exp_b[$];
    int unsigned nn;
    int unsigned a;
    int unsigned b;
    int          got;
    int          c;
    int          done_c;
    longint      prev_a;
    logic        pv;
    logic        r;
    logic [W-1:0] pa;
    logic [W-1:0] pb;
    nn = 1 << n;
    for (int unsigned i = 0; i < nn; i++) begin
      if (i < rev_ref(i, n)) begin
        exp_a.push_back(i);
        exp_b.push_back(rev_ref(i, n));
      end
    end
    got = 0;
    c = 0;
    done_c = -1;
    prev_a = -1;
    nof_bits_i = 4'(n);
    shift_i = sh;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    while (c < 20000) begin
      if (done_o) begin
        done_c = c;
        break;
      end
      start_i = inject && (c == 5);
      if (inject && c == 5) begin
        nof_bits_i = 4'd12;
        shift_i = ~sh;
      end
      r = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      swap_if.swap_ready = r;
      pv = swap_if.swap_valid;
      pa = swap_if.swap_idx_a;
      pb = swap_if.swap_idx_b;
      tick();
      c++;
      if (pv && r) begin
        a = sh ? 32'(pa) / 4 : 32'(pa);
        b = sh ? 32'(pb) / 4 : 32'(pb);
        if (got < exp_a.size()) begin
          check_val("swap_a", 32'(pa), fmt_ref(exp_a[got], sh));
          check_val("swap_b", 32'(pb), fmt_ref(exp_b[got], sh));
        end
        check_val("a_lt_b", 32'(a < b), 1);
        check_val("ascending_a", 32'(longint'(a) > prev_a), 1);
        prev_a = longint'(a);
        got++;
      end else if (pv) begin
        check_val("hold_valid", 32'(swap_if.swap_valid), 1);
        check_val("hold_a", 32'(swap_if.swap_idx_a), 32'(pa));
        check_val("hold_b", 32'(swap_if.swap_idx_b), 32'(pb));
      end
    end
    start_i = 1'b0;
    swap_if.swap_ready = 1'b0;
    check_val("swap_count", 32'(got), exp_a.size());
    check_val("done_seen", 32'(done_c >= 0), 1);
    check_val("busy_at_done", 32'(busy_o), 1);
    if (chk_lat) check_val("done_latency", 32'(done_c), nn + exp_a.size());
    tick();
    check_val("done_pulse_end", 32'(done_o), 0);
    check_val("busy_after", 32'(busy_o), 0);
  endtask

  task automatic wait_valid(input string tag);
    int k = 0;
    while (!swap_if.swap_valid && k < 500) begin
      tick();
      k++;
    end
    check_val(tag, 32'(swap_if.swap_valid), 1);
  endtask

  initial begin
    int seen_done;
    swap_if.swap_ready = 1'b0;
    #3;
    check_val("rst_busy", 32'(busy_o), 0);
    check_val("rst_done", 32'(done_o), 0);
    check_val("rst_err", 32'(err_o), 0);
    check_val("rst_valid", 32'(swap_if.swap_valid), 0);
    check_val("rst_idx_a", 32'(swap_if.swap_idx_a), 0);
    check_val("rst_idx_b", 32'(swap_if.swap_idx_b), 0);
    #9 rst_ni = 1'b1;
    tick();

    run_seq(6, 1'b0, 1'b0, 1'b1, 1'b0);
    run_seq(12, 1'b1, 1'b0, 1'b1, 1'b0);
    run_seq(7, 1'b0, 1'b1, 1'b0, 1'b0);

    // Illegal widths: one-cycle error pulse, never busy.
    for (int t = 0; t < 2; t++) begin
      nof_bits_i = (t == 0) ? 4'd5 : 4'd13;
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      check_val("err_pulse", 32'(err_o), 1);
      check_val("err_busy", 32'(busy_o), 0);
      tick();
      check_val("err_clear", 32'(err_o), 0);
      check_val("err_no_valid", 32'(swap_if.swap_valid), 0);
      check_val("err_busy2", 32'(busy_o), 0);
    end

    // Abort together with start in IDLE: start ignored.
    nof_bits_i = 4'd6;
    start_i = 1'b1;
    abort_i = 1'b1;
    tick();
    start_i = 1'b0;
    abort_i = 1'b0;
    check_val("idle_abort_busy", 32'(busy_o), 0);
    check_val("idle_abort_err", 32'(err_o), 0);

    // Abort during ISSUE with ready high: abort wins, no done.
    nof_bits_i = 4'd8;
    shift_i = 1'b0;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    wait_valid("abort_reach_issue");
    swap_if.swap_ready = 1'b1;
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    swap_if.swap_ready = 1'b0;
    check_val("abort_valid", 32'(swap_if.swap_valid), 0);
    check_val("abort_busy", 32'(busy_o), 0);
    seen_done = 0;
    for (int k = 0; k < 20; k++) begin
      if (done_o) seen_done = 1;
      tick();
    end
    check_val("abort_no_done", 32'(seen_done), 0);
    run_seq(8, 1'b0, 1'b0, 1'b1, 1'b0);

    // Asynchronous reset mid-run while a swap is pending.
    nof_bits_i = 4'd7;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    wait_valid("rst_reach_issue");
    #2 rst_ni = 1'b0;
    #1;
    check_val("async_valid", 32'(swap_if.swap_valid), 0);
    check_val("async_busy", 32'(busy_o), 0);
    check_val("async_done", 32'(done_o), 0);
    check_val("async_idx_a", 32'(swap_if.swap_idx_a), 0);
    check_val("async_idx_b", 32'(swap_if.swap_idx_b), 0);
    #3 rst_ni = 1'b1;
    tick();
    check_val("post_rst_busy", 32'(busy_o), 0);
    run_seq(6, 1'b0, 1'b0, 1'b1, 1'b1);

    for (int t = 0; t < 3; t++) begin
      run_seq($urandom_range(6, 9), 1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
